idelay_lane_loader: RTL

// - Initiator side of the pipelined fine-delay load protocol (ld = stage value, set = apply all staged).
// - Accepts (lane, 8-bit delay) commands over valid/ready, strobes per-lane ld with a shared delay bus.
// - On an apply command issues one common set to all lanes, waits settle time, then reports done.
// - Keeps pending/applied shadow copies per lane for readback; sits between the memory-PHY

---
 rtl/idelay_lane_loader.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/idelay_lane_loader.sv
// Fine-delay load initiator: stages per-lane delays with ld strobes, applies them all with one set.
// Optional build macro IDELAY_LOADER_BCAST_EN: an all-ones lane index broadcasts a load to every lane.
module idelay_lane_loader #(
    parameter int         NUM_LANES     = 8,
    parameter int         LANE_W        = 3,
    parameter logic [7:0] DELAY_VALUE   = 8'h00,
    parameter int         SETTLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_apply,
    input  logic [LANE_W-1:0]    cmd_lane,
    input  logic [7:0]           cmd_delay,
    output logic [NUM_LANES-1:0] dly_ld,
    output logic [7:0]           dly_out,
    output logic                 dly_set,
    output logic                 done,
    output logic                 err_fine,
    output logic                 err_lane,
    input  logic                 err_clr,
    input  logic [LANE_W-1:0]    rd_lane,
    output logic [7:0]           rd_delay
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_SET    = 2'd2;
    localparam logic [1:0] ST_SETTLE = 2'd3;

    localparam int         SETTLE_LAST = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
    localparam logic [3:0] SETTLE_LOAD = SETTLE_LAST[3:0];

    logic [1:0]           state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 ready_q, ready_d;
    logic [NUM_LANES-1:0] ld_q, ld_d;
    logic [7:0]           out_q, out_d;
    logic                 set_q, set_d;
    logic                 done_q, done_d;
    logic                 err_fine_q, err_fine_d;
    logic                 err_lane_q, err_lane_d;
    logic [7:0]           rd_q, rd_d;
    logic [7:0]           pending_q [NUM_LANES];
    logic [7:0]           pending_d [NUM_LANES];
    logic [7:0]           applied_q [NUM_LANES];
    logic [7:0]           applied_d [NUM_LANES];

    logic       accept;
    logic       fine_bad;
    logic [7:0] clamped;
    logic       lane_in_range;
    logic       bcast;

    assign accept        = cmd_valid & ready_q;
    assign fine_bad      = (cmd_delay[2:0] > 3'd4);
    assign clamped       = fine_bad ? {cmd_delay[7:3], 3'd4} : cmd_delay;
    assign lane_in_range = (32'(cmd_lane) < NUM_LANES);
`ifdef IDELAY_LOADER_BCAST_EN
    assign bcast         = &cmd_lane;
`else
    assign bcast         = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ld_d       = '0;
        out_d      = 8'h00;
        set_d      = 1'b0;
        done_d     = 1'b0;
        pending_d  = pending_q;
        applied_d  = applied_q;
        // a new error in the same cycle as err_clr keeps the flag set
        err_fine_d = err_fine_q & ~err_clr;
        err_lane_d = err_lane_q & ~err_clr;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (cmd_apply) begin
                        state_d   = ST_SET;
                        set_d     = 1'b1;
                        applied_d = pending_q;
                    end else begin
                        state_d = ST_LOAD;
                        out_d   = clamped;
                        for (int i = 0; i < NUM_LANES; i++) begin
                            ld_d[i] = bcast | (lane_in_range & (cmd_lane == LANE_W'(i)));
                            if (ld_d[i]) pending_d[i] = clamped;
                        end
                        if (fine_bad) err_fine_d = 1'b1;
                        if (!bcast && !lane_in_range) err_lane_d = 1'b1;
                    end
                end
            end
            ST_LOAD: state_d = ST_IDLE;
            ST_SET: begin
                if (SETTLE_CYCLES == 0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_SETTLE;
                    cnt_d   = SETTLE_LOAD;
                    done_d  = (SETTLE_LOAD == 4'd0);
                end
            end
            ST_SETTLE: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d  = cnt_q - 4'd1;
                    done_d = (cnt_q == 4'd1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_IDLE);

        rd_d = 8'h00;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (rd_lane == LANE_W'(i)) rd_d = applied_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            ready_q    <= 1'b0;
            ld_q       <= '0;
            out_q      <= 8'h00;
            set_q      <= 1'b0;
            done_q     <= 1'b0;
            err_fine_q <= 1'b0;
            err_lane_q <= 1'b0;
            rd_q       <= DELAY_VALUE;
            for (int i = 0; i < NUM_LANES; i++) begin
                pending_q[i] <= DELAY_VALUE;
                applied_q[i] <= DELAY_VALUE;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ready_q    <= ready_d;
            ld_q       <= ld_d;
            out_q      <= out_d;
            set_q      <= set_d;
            done_q     <= done_d;
            err_fine_q <= err_fine_d;
            err_lane_q <= err_lane_d;
            rd_q       <= rd_d;
            pending_q  <= pending_d;
            applied_q  <= applied_d;
        end
    end

    assign cmd_ready = ready_q;
    assign dly_ld    = ld_q;
    assign dly_out   = out_q;
    assign dly_set   = set_q;
    assign done      = done_q;
    assign err_fine  = err_fine_q;
    assign err_lane  = err_lane_q;
    assign rd_delay  = rd_q;

endmodule
